// File: rtl/sprite_pkg.sv
// Shared constants for the sprite display: default bitmap geometry, sprite
// image selects and renderer indices used by the ROM arbiter.
package sprite_pkg;

    localparam int DEFAULT_ROW_W = 4;
    localparam int DEFAULT_SEL_W = 2;
    localparam int DEFAULT_BMP_W = 8;

    // Requester tags are always carried in 3 bits so up to 8 renderers fit.
    localparam int IDX_W = 3;

    typedef enum logic [1:0] {
        SPR_PLAYER  = 2'd0,
        SPR_ENEMY_A = 2'd1,
        SPR_ENEMY_B = 2'd2,
        SPR_ENEMY_C = 2'd3
    } sprite_sel_e;

    localparam int REQ_PLAYER  = 0;
    localparam int REQ_ENEMY_A = 1;
    localparam int REQ_ENEMY_B = 2;
    localparam int REQ_ENEMY_C = 3;

    function automatic int rr_index(input int base, input int offset, input int n);
        return (base + offset) % n;
    endfunction

endpackage

// File: rtl/sprite_rom_arbiter_rr_picker.sv
// Combinational round-robin picker: first eligible requester after the last
// winner, wrapping modulo NUM_REQ.
module rr_picker
    import sprite_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] eligible_i,
    input  logic [IDX_W-1:0]   last_grant_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   grant_idx_o,
    output logic               any_o
);

    logic found;
    int   cand;

    // Offsets run 1..NUM_REQ so the last winner is considered last.
    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        cand        = 0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand = rr_index(int'(last_grant_i), off, NUM_REQ);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!found && (i == cand) && eligible_i[i]) begin
                    grant_o[i]  = 1'b1;
                    grant_idx_o = IDX_W'(i);
                    found       = 1'b1;
                end
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one synchronous sprite ROM between renderers;
// grant, ROM access and write-back form a three-edge pipeline.
module sprite_rom_arbiter
    import sprite_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ROW_W   = DEFAULT_ROW_W,
    parameter int SEL_W   = DEFAULT_SEL_W,
    parameter int BMP_W   = DEFAULT_BMP_W
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [NUM_REQ*ROW_W-1:0]   req_row_i,
    input  logic [NUM_REQ*SEL_W-1:0]   req_sel_i,
    output logic [NUM_REQ-1:0]         ack_o,
    output logic [NUM_REQ*BMP_W-1:0]   bits_o,
    output logic                       rom_en_o,
    output logic [SEL_W+ROW_W-1:0]     rom_addr_o,
    input  logic [BMP_W-1:0]           rom_data_i,
    output logic [IDX_W-1:0]           grant_id_o
);

    localparam int ADDR_W = SEL_W + ROW_W;

    logic [NUM_REQ-1:0]       eligible;
    logic [NUM_REQ-1:0]       grant_oh;
    logic [IDX_W-1:0]         grant_idx;
    logic                     grant_any;

    logic [NUM_REQ-1:0]       in_flight_q, in_flight_d;
    logic [IDX_W-1:0]         last_grant_q, last_grant_d;
    logic                     rom_en_q, rom_en_d;
    logic [ADDR_W-1:0]        rom_addr_q, rom_addr_d;
    logic [IDX_W-1:0]         grant_id_q, grant_id_d;
    logic                     valid2_q;
    logic [IDX_W-1:0]         tag2_q;
    logic [NUM_REQ-1:0]       complete;
    logic [NUM_REQ-1:0]       ack_q;
    logic [NUM_REQ*BMP_W-1:0] bits_q, bits_d;

    assign eligible = req_i & ~in_flight_q;

    rr_picker #(
        .NUM_REQ(NUM_REQ)
    ) u_picker (
        .eligible_i  (eligible),
        .last_grant_i(last_grant_q),
        .grant_o     (grant_oh),
        .grant_idx_o (grant_idx),
        .any_o       (grant_any)
    );

    // Stage 1 is the ROM command register itself: rom_en/grant_id act as
    // the valid/tag that the write-back stage follows one edge later.
    always_comb begin
        rom_en_d     = grant_any;
        grant_id_d   = grant_any ? grant_idx : '0;
        rom_addr_d   = rom_addr_q;
        last_grant_d = grant_any ? grant_idx : last_grant_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_oh[i]) begin
                rom_addr_d = {req_sel_i[i*SEL_W +: SEL_W], req_row_i[i*ROW_W +: ROW_W]};
            end
        end
    end

    always_comb begin
        complete = '0;
        bits_d   = bits_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (valid2_q && (tag2_q == IDX_W'(i))) begin
                complete[i]               = 1'b1;
                bits_d[i*BMP_W +: BMP_W]  = rom_data_i;
            end
        end
        in_flight_d = (in_flight_q | grant_oh) & ~complete;
    end

    // Reset drops every outstanding read, so nothing granted before reset
    // can acknowledge afterwards.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rom_en_q     <= 1'b0;
            rom_addr_q   <= '0;
            grant_id_q   <= '0;
            valid2_q     <= 1'b0;
            tag2_q       <= '0;
            in_flight_q  <= '0;
            last_grant_q <= IDX_W'(NUM_REQ - 1);
            ack_q        <= '0;
            bits_q       <= '0;
        end else begin
            rom_en_q     <= rom_en_d;
            rom_addr_q   <= rom_addr_d;
            grant_id_q   <= grant_id_d;
            valid2_q     <= rom_en_q;
            tag2_q       <= grant_id_q;
            in_flight_q  <= in_flight_d;
            last_grant_q <= last_grant_d;
            ack_q        <= complete;
            bits_q       <= bits_d;
        end
    end

    assign rom_en_o   = rom_en_q;
    assign rom_addr_o = rom_addr_q;
    assign grant_id_o = grant_id_q;
    assign ack_o      = ack_q;
    assign bits_o     = bits_q;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed bench for sprite_rom_arbiter with a behavioural synchronous ROM.
module tb_sprite_rom_arbiter;
    import sprite_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [15:0] req_row;
    logic [7:0]  req_sel;
    logic [3:0]  ack;
    logic [31:0] bits;
    logic        rom_en;
    logic [5:0]  rom_addr;
    logic [7:0]  rom_data;
    logic [2:0]  grant_id;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]  req;
        logic [15:0] row;
        logic [7:0]  sel;
        logic        expEn;
        logic [2:0]  expGid;
        logic [5:0]  expAddr;
        logic [3:0]  expAck;
    } vec_t;

    vec_t vecs[8];

    sprite_rom_arbiter #(
        .NUM_REQ(4), .ROW_W(4), .SEL_W(2), .BMP_W(8)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .req_i     (req),
        .req_row_i (req_row),
        .req_sel_i (req_sel),
        .ack_o     (ack),
        .bits_o    (bits),
        .rom_en_o  (rom_en),
        .rom_addr_o(rom_addr),
        .rom_data_i(rom_data),
        .grant_id_o(grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] romFn(input logic [5:0] a);
        if (a == 6'h05) return 8'h3C;
        return {2'b10, a};
    endfunction

    // Synchronous ROM: data valid the cycle after rom_en.
    initial rom_data = 8'h00;
    always @(posedge clk) if (rom_en) rom_data <= romFn(rom_addr);

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input vec_t v);
        req     = v.req;
        req_row = v.row;
        req_sel = v.sel;
    endtask

    task automatic doReset();
        rst_n   = 1'b0;
        req     = '0;
        req_row = '0;
        req_sel = '0;
        step();
        checkOutput("reset rom_en", 32'(rom_en), 32'd0);
        checkOutput("reset rom_addr", 32'(rom_addr), 32'd0);
        checkOutput("reset grant_id", 32'(grant_id), 32'd0);
        checkOutput("reset ack", 32'(ack), 32'd0);
        checkOutput("reset bits", bits, 32'd0);
        step();
        rst_n = 1'b1;
    endtask

    task automatic runVectors(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            applyStimulus(vecs[i]);
            step();
            checkOutput($sformatf("%s[%0d] rom_en", tag, i), 32'(rom_en), 32'(vecs[i].expEn));
            checkOutput($sformatf("%s[%0d] grant_id", tag, i), 32'(grant_id), 32'(vecs[i].expGid));
            checkOutput($sformatf("%s[%0d] ack", tag, i), 32'(ack), 32'(vecs[i].expAck));
            if (vecs[i].expEn)
                checkOutput($sformatf("%s[%0d] rom_addr", tag, i), 32'(rom_addr), 32'(vecs[i].expAddr));
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        req     = '0;
        req_row = '0;
        req_sel = '0;

        // Single request, player row 5
        doReset();
        req     = 4'b0001;
        req_row = 16'h0005;
        req_sel = {2'(SPR_ENEMY_C), 2'(SPR_ENEMY_B), 2'(SPR_ENEMY_A), 2'(SPR_PLAYER)} & 8'h00;
        step();
        checkOutput("single rom_en", 32'(rom_en), 32'd1);
        checkOutput("single rom_addr", 32'(rom_addr), 32'h05);
        checkOutput("single grant_id", 32'(grant_id), 32'(REQ_PLAYER));
        step();
        checkOutput("single ack e2", 32'(ack), 32'd0);
        step();
        checkOutput("single ack e3", 32'(ack), 32'b0001);
        checkOutput("single bits", bits, 32'h0000003C);
        req = 4'b0000;
        step();
        checkOutput("single ack e4", 32'(ack), 32'd0);

        // All four at once, each drops on its ack
        doReset();
        vecs[0] = '{4'b1111, 16'h4321, 8'hE4, 1'b1, 3'd0, 6'h01, 4'b0000};
        vecs[1] = '{4'b1111, 16'h4321, 8'hE4, 1'b1, 3'd1, 6'h12, 4'b0000};
        vecs[2] = '{4'b1111, 16'h4321, 8'hE4, 1'b1, 3'd2, 6'h23, 4'b0001};
        vecs[3] = '{4'b1110, 16'h4321, 8'hE4, 1'b1, 3'd3, 6'h34, 4'b0010};
        vecs[4] = '{4'b1100, 16'h4321, 8'hE4, 1'b0, 3'd0, 6'h00, 4'b0100};
        vecs[5] = '{4'b1000, 16'h4321, 8'hE4, 1'b0, 3'd0, 6'h00, 4'b1000};
        vecs[6] = '{4'b0000, 16'h4321, 8'hE4, 1'b0, 3'd0, 6'h00, 4'b0000};
        runVectors(7, "all4");
        checkOutput("all4 bits", bits, {romFn(6'h34), romFn(6'h23), romFn(6'h12), romFn(6'h01)});

        // Player holds req forever, enemy B asks once
        doReset();
        vecs[0] = '{4'b0101, 16'h0706, 8'h21, 1'b1, 3'd0, 6'h16, 4'b0000};
        vecs[1] = '{4'b0101, 16'h0706, 8'h21, 1'b1, 3'd2, 6'h27, 4'b0000};
        vecs[2] = '{4'b0101, 16'h0706, 8'h21, 1'b0, 3'd0, 6'h00, 4'b0001};
        vecs[3] = '{4'b0101, 16'h0706, 8'h21, 1'b1, 3'd0, 6'h16, 4'b0100};
        vecs[4] = '{4'b0001, 16'h0706, 8'h21, 1'b0, 3'd0, 6'h00, 4'b0000};
        vecs[5] = '{4'b0001, 16'h0706, 8'h21, 1'b0, 3'd0, 6'h00, 4'b0001};
        vecs[6] = '{4'b0001, 16'h0706, 8'h21, 1'b1, 3'd0, 6'h16, 4'b0000};
        runVectors(7, "hold");
        checkOutput("hold bits", bits, {8'h00, romFn(6'h27), 8'h00, romFn(6'h16)});

        // Row changes after grant
        doReset();
        req     = 4'b0001;
        req_row = 16'h0005;
        req_sel = 8'h00;
        step();
        checkOutput("rowchg addr1", 32'(rom_addr), 32'h05);
        req_row = 16'h0009;
        step();
        checkOutput("rowchg idle", 32'(rom_en), 32'd0);
        step();
        checkOutput("rowchg ack1", 32'(ack), 32'b0001);
        checkOutput("rowchg bits1", bits, 32'h0000003C);
        req = 4'b0000;
        step();
        req = 4'b0001;
        step();
        checkOutput("rowchg en2", 32'(rom_en), 32'd1);
        checkOutput("rowchg addr2", 32'(rom_addr), 32'h09);
        step();
        step();
        checkOutput("rowchg ack2", 32'(ack), 32'b0001);
        checkOutput("rowchg bits2", bits, 32'h00000089);
        req = 4'b0000;

        // Request dropped right after grant
        doReset();
        req     = 4'b0010;
        req_row = 16'h0030;
        req_sel = 8'h04;
        step();
        checkOutput("drop grant_id", 32'(grant_id), 32'd1);
        checkOutput("drop addr", 32'(rom_addr), 32'h13);
        req = 4'b0000;
        step();
        checkOutput("drop en e2", 32'(rom_en), 32'd0);
        step();
        checkOutput("drop ack", 32'(ack), 32'b0010);
        checkOutput("drop bits", bits, 32'h00009300);
        step();
        checkOutput("drop ack e4", 32'(ack), 32'd0);
        checkOutput("drop en e4", 32'(rom_en), 32'd0);

        // Reset while a read is in flight
        doReset();
        req     = 4'b0001;
        req_row = 16'h0005;
        req_sel = 8'h00;
        step();
        checkOutput("midrst en pre", 32'(rom_en), 32'd1);
        rst_n = 1'b0;
        req   = 4'b0000;
        #1;
        checkOutput("midrst en", 32'(rom_en), 32'd0);
        checkOutput("midrst ack", 32'(ack), 32'd0);
        checkOutput("midrst bits", bits, 32'd0);
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checkOutput($sformatf("midrst post ack[%0d]", i), 32'(ack), 32'd0);
            checkOutput($sformatf("midrst post bits[%0d]", i), bits, 32'd0);
        end
        req = 4'b1001;
        step();
        checkOutput("midrst first en", 32'(rom_en), 32'd1);
        checkOutput("midrst first gid", 32'(grant_id), 32'(REQ_PLAYER));
        req = 4'b0000;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
